// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          WORD_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    // One buffered instruction: the word and the address it was fetched from.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO of fetch entries with synchronous clear.
// Used both for the instruction queue and for the in-flight PC tags.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            push_ok;
    logic            pop_ok;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt state.
    always_comb begin
        push_ok = push && (count != CW'(DEPTH));
        pop_ok  = pop && (count != '0);
    end

    assign head = mem[rd_ptr];

    // Pointer, occupancy and storage update; clear empties without touching storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to
// instruction memory under a credit limit, buffers returned words with their
// PCs and hands them to the decoder. Redirects flush buffered words and mark
// in-flight responses as stale so they are discarded on arrival.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, FLUSH} fstate_t;

    fstate_t            state, state_d;
    logic [WORD_W-1:0]  fetch_pc, fetch_pc_d;
    logic [CW-1:0]      outstanding, outstanding_d;
    logic [CW-1:0]      drop, drop_d;

    logic [CW-1:0]      q_count;
    logic [CW-1:0]      t_count;
    fetch_entry_t       q_head;
    fetch_entry_t       t_head;
    fetch_entry_t       q_push_data;
    fetch_entry_t       t_push_data;

    logic [CW:0]        inflight;
    logic               credit;
    logic               rsp_ok;
    logic               req_fire;
    logic               instr_fire;
    logic               q_push;
    logic               unused_tag_instr;

    // Handshake qualification. The tag FIFO tracks exactly the requests still
    // owed a response, so an empty tag FIFO marks a spurious response.
    // A slot popped by the decoder this cycle already counts as free: any
    // request issued now returns at the earliest next cycle, after the pop.
    always_comb begin
        rsp_ok         = imem_rsp_valid && (t_count != '0);
        instr_valid    = !reset && (q_count != '0) && !redirect_valid;
        instr_fire     = instr_valid && instr_ready;
        inflight       = (CW+1)'(q_count) + (CW+1)'(outstanding) - (CW+1)'(instr_fire);
        credit         = inflight < (CW+1)'(DEPTH);
        imem_req_valid = !reset && credit && !redirect_valid;
        imem_req_addr  = reset ? '0 : fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        q_push         = rsp_ok && !redirect_valid && (state == RUN);
        instr          = reset ? '0 : q_head.instr;
        instr_pc       = reset ? '0 : q_head.pc;
        t_push_data    = '{pc: fetch_pc, instr: '0};
        q_push_data    = '{pc: t_head.pc, instr: imem_rsp_data};
    end

    assign unused_tag_instr = ^t_head.instr;

    // Next-state: PC advance, in-flight count, stale-response count and RUN/FLUSH.
    always_comb begin
        fetch_pc_d    = fetch_pc;
        drop_d        = drop;
        outstanding_d = outstanding + CW'(req_fire) - CW'(rsp_ok);
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            // Everything still owed after this cycle's response is stale.
            drop_d     = outstanding - CW'(rsp_ok);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc + PC_INC;
            if (rsp_ok && (drop != '0)) drop_d = drop - CW'(1);
        end
        state_d = (drop_d != '0) ? FLUSH : RUN;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            outstanding <= outstanding_d;
            drop        <= drop_d;
        end
    end

    // Decoder-facing instruction queue; flushed by redirect.
    fetch_fifo #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (instr_fire),
        .head      (q_head),
        .count     (q_count)
    );

    // Issued-address tags, matched to responses in order; survives redirects
    // because stale responses still have to be paired off.
    fetch_fifo #(.DEPTH(DEPTH)) u_tags (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (req_fire),
        .push_data (t_push_data),
        .pop       (rsp_ok),
        .head      (t_head),
        .count     (t_count)
    );

endmodule
